// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame
// geometry and the clocks-per-bit derivation (reused by the future uart_tx).
package uart_rx_pkg;

  // Receiver states; BREAK parks the FSM while the line is held low after a bad stop bit
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS = 32'd8;

  // Clocks per bit period, truncated (50 MHz / 115200 -> 434)
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin. Both stages reset to 1
// so a reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input, idle level high
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge on the synchronised line, samples
// every bit at mid-bit and hands each byte to the core through a one-byte
// holding register with a valid/ready handshake. Framing errors and overruns
// are reported as single-clock pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 32'd50000000,
  parameter int unsigned BAUD   = 32'd115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  // START checks at half a bit so every later full-bit step lands mid-bit
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 32'd2 - 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 32'd1);

  logic                 rx_s;
  rx_state_e            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 done_r;   // good stop bit seen; byte delivered next clock

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Frame FSM: start qualification, mid-bit sampling, stop check, break wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= '0;
      done_r      <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      frame_err_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (!rx_s) begin
            state_r <= ST_START;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= '0;
            if (!rx_s) begin
              state_r <= ST_DATA;
              idx_r   <= 3'd0;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame
              state_r <= ST_IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (idx_r == IDX_LAST) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (rx_s) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
              busy_o  <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              state_r     <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_BREAK: begin
          cnt_r <= '0;
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load on delivery when free or being drained, else flag overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done_r) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_r;
          valid_o <= 1'b1;
        end else begin
          // Old byte is kept; the new one is lost
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end else begin
        valid_o <= valid_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx. The DUT runs at 50 clocks per
// bit so that a few hundred frames fit in a short run; line timing is derived
// from that figure. Expected bytes and error counts come from a frame-level
// model of what was put on the line.
module tb_uart_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int CPB    = CLK_HZ / BAUD;  // clocks per bit
  localparam int CLK_T  = 20;             // clock period in time units
  localparam int BIT_T  = CPB * CLK_T;    // nominal bit time in time units

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;

  logic [7:0] got_q[$];   // bytes taken over the handshake
  logic [7:0] exp_q[$];   // bytes the model says must arrive
  int         fe_cnt;
  int         ov_cnt;
  int         vrise_cnt;
  time        vrise_t;
  logic       valid_q;
  logic       acc_q;
  logic [7:0] data_q;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #(CLK_T / 2) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one 8N1 frame LSB first; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop_v;
    #(bit_t);
  endtask

  // Monitor: collect accepted bytes, count pulses, check hold and exclusivity rules
  always @(negedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      if (valid_q && !acc_q) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", 32'(data), 32'(data_q));
      end
      if (frame_err || overrun) chk("err_excl", 32'(frame_err & overrun), 32'd0);
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (valid && !valid_q) begin
        vrise_cnt <= vrise_cnt + 1;
        vrise_t   <= $time;
      end
      valid_q <= valid;
      acc_q   <= valid && ready;
      data_q  <= data;
    end
  end

  initial begin
    int  fe0, ov0, vr0, lat, bt, nerr, hold, exp_fe;
    time t_start;
    logic [7:0] b;
    logic bad;

    checks = 0; errors = 0;
    fe_cnt = 0; ov_cnt = 0; vrise_cnt = 0; vrise_t = 0;
    rx = 1'b1; ready = 1'b0; rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single 0xAA, consumer always ready, latency ~9.5 bits after the edge
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #7;
    got_q.delete(); fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise_cnt;
    t_start = $time;
    send_frame(8'hAA, BIT_T, 1'b1);
    #(BIT_T);
    chk("t1_nvalid", 32'(vrise_cnt - vr0), 32'd1);
    chk("t1_count", 32'(got_q.size()), 32'd1);
    chk("t1_data", 32'((got_q.size() > 0) ? got_q[0] : 8'h00), 32'hAA);
    lat = int'((vrise_t - t_start) / CLK_T);
    chk("t1_latency", 32'((lat >= CPB * 19 / 2) && (lat <= CPB * 19 / 2 + 8)), 32'd1);
    chk("t1_noerr", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // 2: short low glitch is rejected at the half-bit check
    fe0 = fe_cnt; vr0 = vrise_cnt;
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("t2_busy_hi", 32'(busy), 32'd1);
    repeat (CPB / 5 - 8) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
    #1 chk("t2_busy_lo", 32'(busy), 32'd0);
    repeat (2 * CPB) @(posedge clk);
    chk("t2_novalid", 32'(vrise_cnt - vr0), 32'd0);
    chk("t2_noferr", 32'(fe_cnt - fe0), 32'd0);

    // 3: stop bit low plus 2 bit-times of break, then a clean 0x3C
    got_q.delete(); fe0 = fe_cnt; vr0 = vrise_cnt; ov0 = ov_cnt;
    send_frame(8'h55, BIT_T, 1'b0);
    #(2 * BIT_T);
    rx = 1'b1;
    #(BIT_T);
    chk("t3_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_novalid", 32'(vrise_cnt - vr0), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    send_frame(8'h3C, BIT_T, 1'b1);
    #(BIT_T);
    chk("t3_count", 32'(got_q.size()), 32'd1);
    chk("t3_data", 32'((got_q.size() > 0) ? got_q[0] : 8'h00), 32'h3C);
    chk("t3_ferr_once", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_noovr", 32'(ov_cnt - ov0), 32'd0);

    // 4: consumer stalled, second byte overruns, first byte survives
    @(posedge clk); #1 ready = 1'b0;
    got_q.delete(); ov0 = ov_cnt; vr0 = vrise_cnt; fe0 = fe_cnt;
    send_frame(8'h12, BIT_T, 1'b1);
    #(BIT_T);
    send_frame(8'h34, BIT_T, 1'b1);
    #(BIT_T);
    @(negedge clk);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_data", 32'(data), 32'h12);
    chk("t4_ovr", 32'(ov_cnt - ov0), 32'd1);
    chk("t4_nvalid", 32'(vrise_cnt - vr0), 32'd1);
    chk("t4_noferr", 32'(fe_cnt - fe0), 32'd0);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    chk("t4_drop", 32'(valid), 32'd0);
    chk("t4_count", 32'(got_q.size()), 32'd1);
    chk("t4_taken", 32'((got_q.size() > 0) ? got_q[0] : 8'h00), 32'h12);

    // 5: back-to-back 0xAA frames on a slightly slow line
    @(posedge clk); #1 ready = 1'b1;
    got_q.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 32; i++) send_frame(8'hAA, BIT_T + BIT_T / 200, 1'b1);
    #(BIT_T);
    chk("t5_count", 32'(got_q.size()), 32'd32);
    nerr = 0;
    foreach (got_q[i]) if (got_q[i] !== 8'hAA) nerr++;
    chk("t5_bad_bytes", 32'(nerr), 32'd0);
    chk("t5_noerr", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // Random phase: random bytes, rates within +/-2%, occasional bad stop bits
    got_q.delete(); exp_q.delete(); fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom_range(0, 255));
      bt  = BIT_T * $urandom_range(980, 1020) / 1000;
      bad = ($urandom_range(0, 7) == 0);
      #($urandom_range(0, CLK_T - 1));
      if (bad) begin
        send_frame(b, bt, 1'b0);
        hold = $urandom_range(1, 3);
        #(hold * bt);
        rx = 1'b1;
        #(bt);
        exp_fe++;
      end else begin
        send_frame(b, bt, 1'b1);
        exp_q.push_back(b);
        #($urandom_range(0, 2) * bt);
      end
    end
    #(BIT_T);
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rnd_ferr", 32'(fe_cnt - fe0), 32'(exp_fe));
    chk("rnd_noovr", 32'(ov_cnt - ov0), 32'd0);

    // 6: reset during data bit 4 with a byte held, then a clean 0x0F
    @(posedge clk); #1 ready = 1'b0;
    send_frame(8'h81, BIT_T, 1'b1);
    #(BIT_T);
    chk("t6_held", 32'(valid), 32'd1);
    fork
      send_frame(8'hF0, BIT_T, 1'b1);
      begin
        #(BIT_T * 5 + BIT_T / 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_valid0", 32'(valid), 32'd0);
        chk("t6_data0", 32'(data), 32'd0);
        chk("t6_busy0", 32'(busy), 32'd0);
      end
    join
    #(BIT_T);
    got_q.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk); #1 ready = 1'b1;
    send_frame(8'h0F, BIT_T, 1'b1);
    #(BIT_T);
    chk("t6_count", 32'(got_q.size()), 32'd1);
    chk("t6_data", 32'((got_q.size() > 0) ? got_q[0] : 8'h00), 32'h0F);
    chk("t6_noerr", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
